// File: rtl/controle_caixas_pkg.sv
// Shared types and widths for the box-packing controller.
// State encoding is fixed so that downstream debug taps can decode it directly.
package controle_caixas_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        SELAGEM = 2'b01,
        ESTEIRA = 2'b10
    } estado_t;

    localparam int TIMER_W  = 4;
    localparam int CAIXAS_W = 4;
    localparam int PEND_W   = 2;

endpackage

// File: rtl/controle_caixas_temporizador_estagio.sv
// Loadable 4-bit down-counter timing one phase of a box; one cycle from load to first count.
// Holds at zero once expired; a load always wins over counting, no backpressure.
module temporizador_estagio
    import controle_caixas_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               carregar,
    input  logic [TIMER_W-1:0] valor,
    output logic               zero
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (carregar) begin
            cnt_d = valor;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/controle_caixas.sv
// Box controller: queues dozen pulses, seals and conveys one box at a time, counts stock.
// Box period SEAL_CYCLES+MOVE_CYCLES+1; stalls on full stock, excess dozens raise a sticky overflow.
module controle_caixas
    import controle_caixas_pkg::*;
#(
    parameter int SEAL_CYCLES = 4,
    parameter int MOVE_CYCLES = 3,
    parameter int MAX_CAIXAS  = 10,
    parameter int PEND_DEPTH  = 3
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                DUZIA_COMPLETA,
    input  logic                ESVAZIAR_ESTOQUE,
    output logic                SELAR,
    output logic                ESTEIRA_CAIXA,
    output logic                CAIXA_PRONTA,
    output logic [CAIXAS_W-1:0] NUM_CAIXAS,
    output logic [PEND_W-1:0]   PENDENTES,
    output logic                ESTOQUE_CHEIO,
    output logic                ERRO_OVERFLOW
);

    localparam logic [TIMER_W-1:0]  SEAL_VAL = TIMER_W'(SEAL_CYCLES - 1);
    localparam logic [TIMER_W-1:0]  MOVE_VAL = TIMER_W'(MOVE_CYCLES - 1);
    localparam logic [CAIXAS_W-1:0] MAX_NUM  = CAIXAS_W'(MAX_CAIXAS);
    localparam logic [PEND_W-1:0]   PEND_MAX = PEND_W'(PEND_DEPTH);

    estado_t             estado_q, estado_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic [CAIXAS_W-1:0] num_q, num_d;
    logic                ovf_q, ovf_d;
    logic                pronta_q, pronta_d;
    logic                selar_q, selar_d;
    logic                esteira_q, esteira_d;

    logic                cheio;
    logic                inicio;
    logic                fim;
    logic                timer_zero;
    logic                timer_load;
    logic [TIMER_W-1:0]  timer_val;

    temporizador_estagio u_temporizador (
        .clk      (CLOCK),
        .rst_n    (RESET),
        .carregar (timer_load),
        .valor    (timer_val),
        .zero     (timer_zero)
    );

    always_comb begin
        cheio  = (num_q == MAX_NUM);
        inicio = (estado_q == OCIOSO) && ((pend_q != '0) || DUZIA_COMPLETA) && !cheio;
        fim    = (estado_q == ESTEIRA) && timer_zero;

        estado_d   = estado_q;
        timer_load = 1'b0;
        timer_val  = SEAL_VAL;
        case (estado_q)
            OCIOSO: begin
                if (inicio) begin
                    estado_d   = SELAGEM;
                    timer_load = 1'b1;
                    timer_val  = SEAL_VAL;
                end
            end
            SELAGEM: begin
                if (timer_zero) begin
                    estado_d   = ESTEIRA;
                    timer_load = 1'b1;
                    timer_val  = MOVE_VAL;
                end
            end
            ESTEIRA: begin
                if (timer_zero) begin
                    estado_d = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase

        // A pulse that starts a box directly never touches the queue.
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (DUZIA_COMPLETA && !inicio) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (!DUZIA_COMPLETA && inicio) begin
            pend_d = pend_q - PEND_W'(1);
        end

        // Clearing on a completion edge keeps the box just finished.
        num_d = num_q;
        if (ESVAZIAR_ESTOQUE) begin
            num_d = fim ? CAIXAS_W'(1) : '0;
        end else if (fim) begin
            num_d = num_q + CAIXAS_W'(1);
        end

        pronta_d  = fim;
        selar_d   = (estado_d == SELAGEM);
        esteira_d = (estado_d == ESTEIRA);
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            estado_q  <= OCIOSO;
            pend_q    <= '0;
            num_q     <= '0;
            ovf_q     <= 1'b0;
            pronta_q  <= 1'b0;
            selar_q   <= 1'b0;
            esteira_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            pend_q    <= pend_d;
            num_q     <= num_d;
            ovf_q     <= ovf_d;
            pronta_q  <= pronta_d;
            selar_q   <= selar_d;
            esteira_q <= esteira_d;
        end
    end

    assign SELAR         = selar_q;
    assign ESTEIRA_CAIXA = esteira_q;
    assign CAIXA_PRONTA  = pronta_q;
    assign NUM_CAIXAS    = num_q;
    assign PENDENTES     = pend_q;
    assign ESTOQUE_CHEIO = cheio;
    assign ERRO_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_controle_caixas.sv
// Bench for controle_caixas: default instance plus a MAX_CAIXAS=2 instance, checked
// every cycle against a box-age model and at hand-computed points.
module tb_controle_caixas;

    localparam int S     = 4;
    localparam int M     = 3;
    localparam int MAXA  = 10;
    localparam int MAXB  = 2;
    localparam int DEPTH = 3;

    logic CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    logic RESET;
    logic duz_a, esv_a, duz_b, esv_b;

    logic       a_selar, a_esteira, a_pronta, a_cheio, a_ovf;
    logic [3:0] a_num;
    logic [1:0] a_pend;
    logic       b_selar, b_esteira, b_pronta, b_cheio, b_ovf;
    logic [3:0] b_num;
    logic [1:0] b_pend;

    controle_caixas dut_a (
        .CLOCK(CLOCK), .RESET(RESET), .DUZIA_COMPLETA(duz_a), .ESVAZIAR_ESTOQUE(esv_a),
        .SELAR(a_selar), .ESTEIRA_CAIXA(a_esteira), .CAIXA_PRONTA(a_pronta),
        .NUM_CAIXAS(a_num), .PENDENTES(a_pend), .ESTOQUE_CHEIO(a_cheio), .ERRO_OVERFLOW(a_ovf)
    );

    controle_caixas #(.MAX_CAIXAS(MAXB)) dut_b (
        .CLOCK(CLOCK), .RESET(RESET), .DUZIA_COMPLETA(duz_b), .ESVAZIAR_ESTOQUE(esv_b),
        .SELAR(b_selar), .ESTEIRA_CAIXA(b_esteira), .CAIXA_PRONTA(b_pronta),
        .NUM_CAIXAS(b_num), .PENDENTES(b_pend), .ESTOQUE_CHEIO(b_cheio), .ERRO_OVERFLOW(b_ovf)
    );

    logic [10:0] out_a, out_b;
    assign out_a = {a_selar, a_esteira, a_pronta, a_num, a_pend, a_cheio, a_ovf};
    assign out_b = {b_selar, b_esteira, b_pronta, b_num, b_pend, b_cheio, b_ovf};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // age = cycles since the current box started (0 = no box in progress)
    typedef struct {
        int age;
        int pend;
        int num;
        bit ovf;
        bit pronta;
    } mdl_t;

    mdl_t ma, mb;
    bit   mdl_ok = 1'b0;

    function automatic mdl_t model_step(mdl_t m, bit rst_n, bit d, bit e, int maxc);
        mdl_t n;
        bit   start;
        bit   done;
        n = m;
        if (!rst_n) begin
            n.age = 0; n.pend = 0; n.num = 0; n.ovf = 1'b0; n.pronta = 1'b0;
            return n;
        end
        start = (m.age == 0) && (m.pend > 0 || d) && (m.num != maxc);
        done  = (m.age == S + M);
        if (d && !start && m.pend == DEPTH) n.ovf = 1'b1;
        else n.pend = m.pend + (d ? 1 : 0) - (start ? 1 : 0);
        if (start) n.age = 1;
        else if (done) n.age = 0;
        else if (m.age > 0) n.age = m.age + 1;
        if (e) n.num = done ? 1 : 0;
        else n.num = m.num + (done ? 1 : 0);
        n.pronta = done;
        return n;
    endfunction

    function automatic logic [10:0] model_out(mdl_t m, int maxc);
        logic [10:0] v;
        v = {(m.age >= 1 && m.age <= S), (m.age > S), m.pronta, 4'(m.num), 2'(m.pend),
             (m.num == maxc), m.ovf};
        return v;
    endfunction

    always @(posedge CLOCK) begin
        ma = model_step(ma, RESET, duz_a, esv_a, MAXA);
        mb = model_step(mb, RESET, duz_b, esv_b, MAXB);
        if (!RESET) mdl_ok = 1'b1;
        cyc++;
    end

    always @(negedge CLOCK) begin
        if (mdl_ok) begin
            checks++;
            if (out_a !== model_out(ma, MAXA)) begin
                errors++;
                $display("FAIL model_a cyc %0d got %b want %b", cyc, out_a, model_out(ma, MAXA));
            end
            checks++;
            if (out_b !== model_out(mb, MAXB)) begin
                errors++;
                $display("FAIL model_b cyc %0d got %b want %b", cyc, out_b, model_out(mb, MAXB));
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLOCK);
        #1;
    endtask

    int peak, n, first, last;

    initial begin
        RESET = 1'b0;
        duz_a = 1'b0; esv_a = 1'b0; duz_b = 1'b0; esv_b = 1'b0;
        repeat (2) nxt();
        chk("reset_a", int'(out_a), 0);
        chk("reset_b", int'(out_b), 0);
        RESET = 1'b1;
        nxt();

        // single dozen: SELAR 1..4, ESTEIRA 5..7, done at 8
        duz_a = 1'b1; nxt(); duz_a = 1'b0;
        for (int t = 1; t <= 9; t++) begin
            chk($sformatf("single_selar_c%0d", t), int'(a_selar), (t >= 1 && t <= 4) ? 1 : 0);
            chk($sformatf("single_esteira_c%0d", t), int'(a_esteira), (t >= 5 && t <= 7) ? 1 : 0);
            chk($sformatf("single_pronta_c%0d", t), int'(a_pronta), (t == 8) ? 1 : 0);
            chk($sformatf("single_num_c%0d", t), int'(a_num), (t >= 8) ? 1 : 0);
            nxt();
        end

        // pulses at 0,2,3,5: queue peaks at 3, boxes every 8 cycles from 8
        peak = 0; n = 0; first = -1; last = 0;
        for (int t = 0; t < 40; t++) begin
            duz_a = (t == 0 || t == 2 || t == 3 || t == 5);
            if (int'(a_pend) > peak) peak = int'(a_pend);
            if (a_pronta) begin
                if (n == 0) first = t;
                else chk("queue_gap", t - last, 8);
                last = t;
                n++;
            end
            nxt();
        end
        duz_a = 1'b0;
        chk("queue_peak", peak, 3);
        chk("queue_boxes", n, 4);
        chk("queue_first", first, 8);
        chk("queue_ovf", int'(a_ovf), 0);
        chk("queue_num", int'(a_num), 5);

        // clear on the completion edge with stock 5
        duz_a = 1'b1; nxt(); duz_a = 1'b0;
        repeat (6) nxt();
        chk("clr_before_num", int'(a_num), 5);
        esv_a = 1'b1; nxt(); esv_a = 1'b0;
        chk("clr_num", int'(a_num), 1);
        chk("clr_pronta", int'(a_pronta), 1);
        repeat (2) nxt();

        // six pulses at 0..5: two dropped, four boxes
        n = 0;
        for (int t = 0; t < 45; t++) begin
            duz_a = (t <= 5);
            if (t == 4) chk("ovf_c4", int'(a_ovf), 0);
            if (t == 5) begin
                chk("ovf_c5", int'(a_ovf), 1);
                chk("ovf_pend_c5", int'(a_pend), 3);
            end
            if (a_pronta) n++;
            nxt();
        end
        duz_a = 1'b0;
        chk("ovf_boxes", n, 4);
        chk("ovf_num", int'(a_num), 5);
        chk("ovf_sticky", int'(a_ovf), 1);

        // MAX_CAIXAS=2 instance: three dozens, stall at full, clear releases the third
        for (int t = 0; t < 20; t++) begin
            duz_b = (t <= 2);
            nxt();
        end
        duz_b = 1'b0;
        chk("full_num", int'(b_num), 2);
        chk("full_cheio", int'(b_cheio), 1);
        chk("full_pend", int'(b_pend), 1);
        chk("full_idle", int'({b_selar, b_esteira}), 0);
        esv_b = 1'b1; nxt(); esv_b = 1'b0;
        chk("full_clr_num", int'(b_num), 0);
        chk("full_clr_cheio", int'(b_cheio), 0);
        chk("full_clr_selar", int'(b_selar), 0);
        nxt();
        chk("full_start_selar", int'(b_selar), 1);
        chk("full_start_pend", int'(b_pend), 0);
        repeat (7) nxt();
        chk("full_end_pronta", int'(b_pronta), 1);
        chk("full_end_num", int'(b_num), 1);
        repeat (2) nxt();

        // reset in SELAGEM cycle 3 with two queued; inputs on the reset edge ignored
        duz_a = 1'b1; nxt(); nxt(); nxt();
        chk("rst_pre_pend", int'(a_pend), 2);
        chk("rst_pre_selar", int'(a_selar), 1);
        RESET = 1'b0; esv_a = 1'b1;
        nxt();
        RESET = 1'b1; duz_a = 1'b0; esv_a = 1'b0;
        chk("rst_outputs", int'(out_a), 0);
        nxt();
        duz_a = 1'b1; nxt(); duz_a = 1'b0;
        chk("rst_after_selar", int'(a_selar), 1);
        repeat (4) nxt();
        chk("rst_after_esteira", int'(a_esteira), 1);
        repeat (3) nxt();
        chk("rst_after_pronta", int'(a_pronta), 1);
        chk("rst_after_num", int'(a_num), 1);
        repeat (3) nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_caixas.md
# controle_caixas

Box-packing controller placed directly downstream of the bottle counter. It consumes the one-cycle dozen-complete pulse, queues up to PEND_DEPTH pending dozens, and runs each box through a sealing phase and an out-feed conveyor phase. It counts finished boxes into a bounded stock, stalls when the stock is full, and flags lost dozens.

## Interface
Parameters:
- SEAL_CYCLES, 4, cycles SELAR is held high per box (legal 1..15)
- MOVE_CYCLES, 3, cycles ESTEIRA_CAIXA is held high per box (legal 1..15)
- MAX_CAIXAS, 10, stock capacity in boxes (legal 1..15)
- PEND_DEPTH, 3, maximum queued dozens (legal 1..3)

Ports:
- CLOCK  in  1  sole clock, rising edge
- RESET  in  1  synchronous, active-low reset
- DUZIA_COMPLETA  in  1  one-cycle pulse from the bottle counter
- ESVAZIAR_ESTOQUE  in  1  synchronous clear of the stock count
- SELAR  out  1  sealer drive
- ESTEIRA_CAIXA  out  1  out-feed conveyor drive
- CAIXA_PRONTA  out  1  one-cycle pulse when a box is completed
- NUM_CAIXAS  out  4  boxes in stock (0..MAX_CAIXAS)
- PENDENTES  out  2  queued dozens not yet started
- ESTOQUE_CHEIO  out  1  NUM_CAIXAS == MAX_CAIXAS
- ERRO_OVERFLOW  out  1  sticky flag: a dozen was dropped

## Operation
- States: OCIOSO, SELAGEM, ESTEIRA. All outputs are registered or decoded from state (Moore). SELAR=1 only in SELAGEM. ESTEIRA_CAIXA=1 only in ESTEIRA.
- Queue, per edge: PENDENTES_next = PENDENTES + DUZIA_COMPLETA − start. Here start = (state==OCIOSO) & (PENDENTES>0 | DUZIA_COMPLETA) & !ESTOQUE_CHEIO.
  - A pulse arriving in OCIOSO with an empty queue starts the box directly and never appears in PENDENTES.
- Overflow: DUZIA_COMPLETA=1, PENDENTES==PEND_DEPTH and no start on the same edge → the dozen is dropped, PENDENTES is unchanged, ERRO_OVERFLOW is set. Only RESET clears ERRO_OVERFLOW.
- OCIOSO → SELAGEM on start. The timer is loaded with SEAL_CYCLES−1.
- SELAGEM → ESTEIRA when the timer reaches 0. The timer is loaded with MOVE_CYCLES−1.
- ESTEIRA → OCIOSO when the timer reaches 0. On that same edge NUM_CAIXAS increments and CAIXA_PRONTA is set for exactly the next cycle.
- Stock full: start is blocked. Arriving dozens keep queueing under the normal overflow rule.
  - A box in progress at NUM_CAIXAS = MAX_CAIXAS−1 completes normally and brings the stock to full.
- ESVAZIAR_ESTOQUE: NUM_CAIXAS becomes 0 at the edge. If a box completes on the same edge, NUM_CAIXAS becomes 1 and CAIXA_PRONTA still pulses, so no box is lost.
- DUZIA_COMPLETA is never missed while the state machine is busy. It is either queued or counted as an overflow.

## Timing
- Reset, with RESET=0 at an edge: state OCIOSO, timer 0, NUM_CAIXAS=0, PENDENTES=0, ERRO_OVERFLOW=0, CAIXA_PRONTA=0, SELAR=0, ESTEIRA_CAIXA=0, ESTOQUE_CHEIO=0.
  - Reset mid-box aborts the box without incrementing the stock.
  - Inputs sampled on a reset edge are ignored.
- Latency from a pulse in cycle t while in OCIOSO with an empty, non-full stock:
  - SELAR high in cycles t+1 .. t+SEAL_CYCLES.
  - ESTEIRA_CAIXA high in the following MOVE_CYCLES cycles.
  - CAIXA_PRONTA=1 and the new NUM_CAIXAS are visible in cycle t+SEAL_CYCLES+MOVE_CYCLES+1.
- Back-to-back boxes: the CAIXA_PRONTA cycle is an OCIOSO cycle, so the next box can start on that edge. The box period is therefore SEAL_CYCLES+MOVE_CYCLES+1 cycles.
- ESTOQUE_CHEIO is valid in the same cycle as NUM_CAIXAS.

## Structure
- Shared package holds:
  - the state encoding (OCIOSO=2'b00, SELAGEM=2'b01, ESTEIRA=2'b10)
  - the timer width (4)
  - the count widths
- Sub-module temporizador_estagio: a 4-bit loadable down-counter with load, load value and zero flag, used for both phases.
- The queue counter, stock counter and state machine stay in controle_caixas.

## Test plan
- Single dozen, defaults: pulse at cycle 0 → SELAR cycles 1–4, ESTEIRA_CAIXA cycles 5–7, CAIXA_PRONTA=1 and NUM_CAIXAS=1 in cycle 8.
- Pulses at cycles 0, 2, 3, 5 → PENDENTES peaks at 3, no overflow. Four CAIXA_PRONTA pulses 8 cycles apart, starting at cycle 8.
- Five pulses at cycles 1–5 while busy with the box started at cycle 0 → PENDENTES=3, ERRO_OVERFLOW=1 from cycle 5, exactly 4 boxes completed.
- MAX_CAIXAS=2, three dozens → NUM_CAIXAS=2, ESTOQUE_CHEIO=1, PENDENTES=1 and the state machine idle. Pulse ESVAZIAR_ESTOQUE → the third box starts on the next edge and NUM_CAIXAS=1 at its end.
- ESVAZIAR_ESTOQUE on the completion edge with NUM_CAIXAS=5 → NUM_CAIXAS=1 and CAIXA_PRONTA=1.
- RESET=0 in cycle 3 of SELAGEM with PENDENTES=2 → all outputs 0 next cycle. A pulse after release restarts from OCIOSO with the cycle-0 latency.
